// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: pc, single outstanding imem read, redirect handling.
// Optional one-entry skid buffer behind inst_out enabled by defining IF_PREFETCH_EN.
module if_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_from_im,
  input  logic             im_ready,
  output logic [WIDTH-1:0] address_to_im,
  output logic             im_read,
  output logic [WIDTH-1:0] inst_out,
  output logic [WIDTH-1:0] pc_out,
  output logic             inst_valid,
  input  logic             id_ready,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc
);

  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] drop_addr_q, drop_addr_d;
  logic [WIDTH-1:0] inst_d, pcout_d;
  logic             valid_d;
  logic [WIDTH-1:0] target;
  logic             consume, capture;

`ifdef IF_PREFETCH_EN
  logic [WIDTH-1:0] buf_inst_q, buf_inst_d;
  logic [WIDTH-1:0] buf_pc_q, buf_pc_d;
  logic             buf_valid_q, buf_valid_d;
`endif

  assign target  = redirect_pc & ~WIDTH'(3);
  assign consume = inst_valid & id_ready;
  assign capture = (state_q == FETCH) & im_ready & ~redirect_valid;

  // The request drops out combinationally so an abandoned read ends with reset.
  assign im_read       = reset & (state_q != WAIT);
  assign address_to_im = (state_q == DROP) ? drop_addr_q : pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    inst_d      = inst_out;
    pcout_d     = pc_out;
    valid_d     = inst_valid;
`ifdef IF_PREFETCH_EN
    buf_inst_d  = buf_inst_q;
    buf_pc_d    = buf_pc_q;
    buf_valid_d = buf_valid_q;
`endif
    if (redirect_valid) begin
      pc_d    = target;
      valid_d = 1'b0;
`ifdef IF_PREFETCH_EN
      buf_valid_d = 1'b0;
`endif
      case (state_q)
        FETCH: begin
          if (!im_ready) begin
            state_d     = DROP;
            drop_addr_d = pc_q;
          end
        end
        WAIT:    state_d = FETCH;
        DROP:    if (im_ready) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end else begin
      if (state_q == DROP && im_ready) state_d = FETCH;
      if (capture) pc_d = pc_q + WIDTH'(4);
`ifndef IF_PREFETCH_EN
      if (capture) begin
        inst_d  = data_from_im;
        pcout_d = pc_q;
        valid_d = 1'b1;
        state_d = WAIT;
      end else if (state_q == WAIT && consume) begin
        valid_d = 1'b0;
        state_d = FETCH;
      end
`else
      if (consume && buf_valid_q) begin
        inst_d  = buf_inst_q;
        pcout_d = buf_pc_q;
        if (capture) begin
          buf_inst_d = data_from_im;
          buf_pc_d   = pc_q;
        end else begin
          buf_valid_d = 1'b0;
        end
      end else if (consume) begin
        if (capture) begin
          inst_d  = data_from_im;
          pcout_d = pc_q;
        end else begin
          valid_d = 1'b0;
        end
      end else if (capture) begin
        if (inst_valid) begin
          buf_inst_d  = data_from_im;
          buf_pc_d    = pc_q;
          buf_valid_d = 1'b1;
        end else begin
          inst_d  = data_from_im;
          pcout_d = pc_q;
          valid_d = 1'b1;
        end
      end
      // Requesting stops only when both holding entries are occupied.
      if (state_q != DROP) state_d = (valid_d && buf_valid_d) ? WAIT : FETCH;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      inst_out    <= '0;
      pc_out      <= '0;
      inst_valid  <= 1'b0;
`ifdef IF_PREFETCH_EN
      buf_inst_q  <= '0;
      buf_pc_q    <= '0;
      buf_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      inst_out    <= inst_d;
      pc_out      <= pcout_d;
      inst_valid  <= valid_d;
`ifdef IF_PREFETCH_EN
      buf_inst_q  <= buf_inst_d;
      buf_pc_q    <= buf_pc_d;
      buf_valid_q <= buf_valid_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage against a queue-level fetch model.
module tb_if_stage;

  localparam logic [31:0] RPC = 32'h0000_0000;
`ifdef IF_PREFETCH_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_from_im, address_to_im, inst_out, pc_out;
  logic [31:0] redirect_pc = '0;
  logic        im_ready = 1'b0, id_ready = 1'b0, redirect_valid = 1'b0;
  logic        im_read, inst_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A3C_96E1 ^ {a[15:0], a[31:16]};
  endfunction

  assign data_from_im = mem(address_to_im);

  if_stage #(.WIDTH(32), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .data_from_im(data_from_im), .im_ready(im_ready),
    .address_to_im(address_to_im), .im_read(im_read), .inst_out(inst_out),
    .pc_out(pc_out), .inst_valid(inst_valid), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: instructions held for decode are a queue of bounded depth; a
  // redirect empties it and, if a read is still outstanding, the next memory
  // response is swallowed.
  typedef struct packed {logic [31:0] pc; logic [31:0] d;} ent_t;
  ent_t        q[$];
  logic [31:0] m_pc = RPC;
  logic [31:0] m_daddr = RPC;
  bit          m_drop = 1'b0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      q.delete();
      m_pc   = RPC;
      m_drop = 1'b0;
    end else begin
      bit rd, cons;
      rd   = m_drop || (q.size() < CAP);
      cons = (q.size() > 0) && id_ready;
      if (redirect_valid) begin
        q.delete();
        if (m_drop) m_drop = !im_ready;
        else if (rd && !im_ready) begin
          m_drop  = 1'b1;
          m_daddr = m_pc;
        end
        m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (m_drop) begin
        if (im_ready) m_drop = 1'b0;
      end else begin
        if (cons) void'(q.pop_front());
        if (rd && im_ready) begin
          q.push_back({m_pc, mem(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("im_read", im_read, reset && (m_drop || q.size() < CAP));
    chk("address_to_im", address_to_im, m_drop ? m_daddr : m_pc);
    chk("inst_valid", inst_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("pc_out", pc_out, q[0].pc);
      chk("inst_out", inst_out, q[0].d);
    end
    if (!reset) begin
      chk("reset_inst_out", inst_out, 32'h0);
      chk("reset_pc_out", pc_out, 32'h0);
    end
  end

  logic        s_read, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;

  task automatic drive(input logic r, input logic [31:0] t, input logic imr, input logic idr);
    redirect_valid = r;
    redirect_pc    = t;
    im_ready       = imr;
    id_ready       = idr;
    @(negedge clk);
    s_read  = im_read;
    s_valid = inst_valid;
    s_addr  = address_to_im;
    s_pc    = pc_out;
    s_inst  = inst_out;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    redirect_valid = 1'b0;
    im_ready       = 1'b0;
    id_ready       = 1'b0;
    reset          = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    int n;
    logic [31:0] t;
    do_reset();

    // Streaming with a single-cycle memory: one instruction every two cycles.
    for (int k = 1; k <= 9; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      chk("stream_valid", s_valid, (k % 2) == 0);
      chk("stream_read", s_read, (k % 2) == 1);
      if (k % 2 == 0) begin
        chk("stream_pc", s_pc, 32'((k / 2 - 1) * 4));
        chk("stream_inst", s_inst, mem(32'((k / 2 - 1) * 4)));
      end else begin
        chk("stream_addr", s_addr, 32'(((k - 1) / 2) * 4));
      end
    end

    // Memory stalls 3 cycles on the fetch at 0x8.
    do_reset();
    repeat (4) drive(1'b0, 32'h0, 1'b1, 1'b1);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, k == 3, 1'b1);
      if (s_read && s_addr == 32'h8 && !s_valid) n++;
    end
    chk("stall_hold_cycles", n, 4);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk("stall_valid", s_valid, 1);
    chk("stall_pc", s_pc, 32'h8);

    // Decode backpressure for 5 cycles at pc 0x4.
    do_reset();
    repeat (3) drive(1'b0, 32'h0, 1'b1, 1'b1);
    n = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      if (s_valid && s_pc == 32'h4 && s_inst == mem(32'h4) && !s_read) n++;
    end
    chk("bp_stable_cycles", n, 5);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk("bp_resume_addr", s_addr, 32'h8);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk("bp_resume_pc", s_pc, 32'h8);

    // Redirect to 0x103 while the read at 0x10 is outstanding.
    do_reset();
    repeat (8) drive(1'b0, 32'h0, 1'b1, 1'b1);
    drive(1'b1, 32'h103, 1'b0, 1'b1);
    chk("drop_pending_addr", s_addr, 32'h10);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("drop_old_addr", s_addr, 32'h10);
    chk("drop_read", s_read, 1);
    chk("drop_valid", s_valid, 0);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk("drop_new_addr", s_addr, 32'h100);
    chk("drop_new_valid", s_valid, 0);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk("drop_new_pc", s_pc, 32'h100);
    chk("drop_new_inst", s_inst, mem(32'h100));

    // Redirect to 0x40 coinciding with im_ready in FETCH.
    do_reset();
    drive(1'b1, 32'h40, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("rdr_same_addr", s_addr, 32'h40);
    chk("rdr_same_valid", s_valid, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("rdr_same_valid2", s_valid, 0);

    // pc wrap at the top of the address space, then reset mid-request.
    do_reset();
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk("wrap_addr", s_addr, 32'hFFFF_FFFC);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk("wrap_pc_top", s_pc, 32'hFFFF_FFFC);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("wrap_pc_zero", s_pc, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("midreq_read", s_read, 1);
    chk("midreq_addr", s_addr, 32'h4);
    reset = 1'b0;
    #1;
    chk("async_rst_read", im_read, 0);
    chk("async_rst_valid", inst_valid, 0);
    chk("async_rst_addr", address_to_im, RPC);
    @(posedge clk);
    #2;
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk("restart_addr", s_addr, RPC);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk("restart_pc", s_pc, RPC);

    // Randomized traffic checked every cycle by the model compare.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      t = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      drive(($urandom % 12) == 0, t, ($urandom % 4) != 0, ($urandom % 3) != 0);
      if (i % 700 == 350) begin
        reset = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
